// File: rtl/regfile_pkg.sv
// Shared constants and width helpers for the regfile_sb register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REG_ZERO = 0;

  function automatic int unsigned addr_w_f(input int unsigned nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  function automatic int unsigned cnt_w_f(input int unsigned max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register of regfile_sb.
module sb_counter #(
  parameter int unsigned MAX_PEND = 3,
  parameter int unsigned CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             full,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc/dec on an idle counter means the write-back belonged to an
  // older, untracked write while the new issue is still outstanding.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (inc && dec) begin
      if (cnt_q == '0) cnt_d = CNT_W'(1);
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt       = cnt_q;
  assign busy      = (cnt_q != '0);
  assign full      = (cnt_q >= CNT_W'(MAX_PEND));
  assign underflow = dec && !inc && !flush && (cnt_q == '0);

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN for write-first read forwarding of wb_data.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREG     = 32,
  parameter int unsigned MAX_PEND = 3,
  localparam int unsigned ADDR_W  = addr_w_f(NREG),
  localparam int unsigned CNT_W   = cnt_w_f(MAX_PEND)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              flush,
  output logic              rs1_hazard,
  output logic              rs2_hazard,
  output logic              wb_err
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [XLEN-1:0]             regs_q [NREG];
  logic [NREG-1:0]             inc_v, dec_v, busy_v, full_v, uflow_v;
  logic [NREG-1:0][CNT_W-1:0]  cnt_v;
  logic                        wb_err_q;

  assign inc_v[0]   = 1'b0;
  assign dec_v[0]   = 1'b0;
  assign busy_v[0]  = 1'b0;
  assign full_v[0]  = 1'b0;
  assign uflow_v[0] = 1'b0;
  assign cnt_v[0]   = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    assign inc_v[r] = issue_en && issue_ready && (issue_rd == ADDR_W'(r));
    assign dec_v[r] = wb_en && (wb_addr == ADDR_W'(r));

    sb_counter #(
      .MAX_PEND (MAX_PEND),
      .CNT_W    (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_v[r]),
      .dec       (dec_v[r]),
      .flush     (flush),
      .cnt       (cnt_v[r]),
      .busy      (busy_v[r]),
      .full      (full_v[r]),
      .underflow (uflow_v[r])
    );
  end

  assign issue_ready = (issue_rd == ZERO_A) || !full_v[issue_rd] ||
                       (wb_en && (wb_addr == issue_rd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      wb_err_q <= 1'b0;
    end else begin
      if (wb_en && (wb_addr != ZERO_A)) regs_q[wb_addr] <= wb_data;
      wb_err_q <= wb_err_q | (|uflow_v);
    end
  end

  assign wb_err = wb_err_q;

`ifdef REGFILE_BYPASS_EN
  logic rs1_hit, rs2_hit;

  assign rs1_hit = wb_en && (wb_addr == rs1_addr) && (rs1_addr != ZERO_A);
  assign rs2_hit = wb_en && (wb_addr == rs2_addr) && (rs2_addr != ZERO_A);

  // A forwarded result only clears the hazard if it is the last outstanding write.
  always_comb begin
    rs1_data   = (rs1_addr == ZERO_A) ? '0 : (rs1_hit ? wb_data : regs_q[rs1_addr]);
    rs2_data   = (rs2_addr == ZERO_A) ? '0 : (rs2_hit ? wb_data : regs_q[rs2_addr]);
    rs1_hazard = busy_v[rs1_addr] && !(rs1_hit && (cnt_v[rs1_addr] == CNT_W'(1)));
    rs2_hazard = busy_v[rs2_addr] && !(rs2_hit && (cnt_v[rs2_addr] == CNT_W'(1)));
  end
`else
  logic cnt_unused;

  assign cnt_unused = ^cnt_v;

  always_comb begin
    rs1_data   = (rs1_addr == ZERO_A) ? '0 : regs_q[rs1_addr];
    rs2_data   = (rs2_addr == ZERO_A) ? '0 : regs_q[rs2_addr];
    rs1_hazard = busy_v[rs1_addr];
    rs2_hazard = busy_v[rs2_addr];
  end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb; honours REGFILE_BYPASS_EN if defined.
module tb_regfile_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned MAXP = 3;
  localparam int unsigned AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1_addr, rs2_addr, wb_addr, issue_rd;
  logic [XLEN-1:0] rs1_data, rs2_data, wb_data;
  logic            wb_en, issue_en, issue_ready, flush;
  logic            rs1_hazard, rs2_hazard, wb_err;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            haz;
  } exp_t;

  exp_t            sb_q[$];
  exp_t            e;
  logic [XLEN-1:0] m_regs [NREG];
  int              n_tests = 0;
  int              n_fail  = 0;

  regfile_sb #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .MAX_PEND (MAXP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .flush       (flush),
    .rs1_hazard  (rs1_hazard),
    .rs2_hazard  (rs2_hazard),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) m_regs[i] = '0;
    sb_q.delete();
  endtask

  task automatic model_wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    if (a != '0) m_regs[a] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    rs1_addr = 5'd5; rs2_addr = 5'd3; issue_rd = 5'd7;
    model_reset();
    @(negedge clk);
    #1;
    n_tests++; if (rs1_data !== '0) begin n_fail++; $display("FAIL reset_rs1_data got %h want 0", rs1_data); end
    n_tests++; if (rs2_data !== '0) begin n_fail++; $display("FAIL reset_rs2_data got %h want 0", rs2_data); end
    n_tests++; if (rs1_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_rs1_hazard got %b want 0", rs1_hazard); end
    n_tests++; if (rs2_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_rs2_hazard got %b want 0", rs2_hazard); end
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got %b want 1", issue_ready); end
    n_tests++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_wb_err got %b want 0", wb_err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    issue_en = 1'b1; issue_rd = 5'd5;
    step();
    issue_en = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    model_wb(wb_addr, wb_data);
    step();
    wb_addr = 5'd0; wb_data = 32'h0000_1234;
    model_wb(wb_addr, wb_data);
    step();
    idle_inputs();
    rs1_addr = 5'd5; rs2_addr = 5'd0;
    sb_q.push_back('{data: m_regs[5], haz: 1'b0});
    sb_q.push_back('{data: m_regs[0], haz: 1'b0});
    #1;
    e = sb_q.pop_front();
    n_tests++; if (rs1_data !== e.data) begin n_fail++; $display("FAIL wr_rs1_data got %h want %h", rs1_data, e.data); end
    n_tests++; if (rs1_hazard !== e.haz) begin n_fail++; $display("FAIL wr_rs1_hazard got %b want %b", rs1_hazard, e.haz); end
    e = sb_q.pop_front();
    n_tests++; if (rs2_data !== e.data) begin n_fail++; $display("FAIL wr_r0_data got %h want %h", rs2_data, e.data); end
    n_tests++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL wr_wb_err got %b want 0", wb_err); end
  endtask

  task automatic test_issue_full();
    rs1_addr = 5'd7;
    for (int i = 0; i < int'(MAXP); i++) begin
      issue_en = 1'b1; issue_rd = 5'd7;
      #1;
      n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_issue%0d_ready got %b want 1", i, issue_ready); end
      step();
    end
    #1;
    n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_4th_ready got %b want 0", issue_ready); end
    n_tests++; if (rs1_hazard !== 1'b1) begin n_fail++; $display("FAIL full_hazard got %b want 1", rs1_hazard); end
    step();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h70;
    model_wb(wb_addr, wb_data);
    #1;
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_wb_ready got %b want 1", issue_ready); end
    step();
    wb_en = 1'b0;
    #1;
    n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_cnt_held got ready %b want 0", issue_ready); end
    step();
    issue_en = 1'b0;
    for (int k = 0; k < int'(MAXP); k++) begin
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h71 + 32'(k);
      model_wb(wb_addr, wb_data);
      step();
    end
    wb_en = 1'b0;
    sb_q.push_back('{data: m_regs[7], haz: 1'b0});
    #1;
    e = sb_q.pop_front();
    n_tests++; if (rs1_data !== e.data) begin n_fail++; $display("FAIL drain_data got %h want %h", rs1_data, e.data); end
    n_tests++; if (rs1_hazard !== e.haz) begin n_fail++; $display("FAIL drain_hazard got %b want %b", rs1_hazard, e.haz); end
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready got %b want 1", issue_ready); end
    n_tests++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL drain_wb_err got %b want 0", wb_err); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    issue_en = 1'b1; issue_rd = 5'd9; rs1_addr = 5'd9;
    step();
    issue_en = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5;
`ifdef REGFILE_BYPASS_EN
    sb_q.push_back('{data: 32'hA5, haz: 1'b0});
`else
    sb_q.push_back('{data: m_regs[9], haz: 1'b1});
`endif
    model_wb(wb_addr, wb_data);
    #1;
    e = sb_q.pop_front();
    n_tests++; if (rs1_data !== e.data) begin n_fail++; $display("FAIL byp_wbcyc_data got %h want %h", rs1_data, e.data); end
    n_tests++; if (rs1_hazard !== e.haz) begin n_fail++; $display("FAIL byp_wbcyc_hazard got %b want %b", rs1_hazard, e.haz); end
    step();
    wb_en = 1'b0;
    sb_q.push_back('{data: m_regs[9], haz: 1'b0});
    #1;
    e = sb_q.pop_front();
    n_tests++; if (rs1_data !== e.data) begin n_fail++; $display("FAIL byp_after_data got %h want %h", rs1_data, e.data); end
    n_tests++; if (rs1_hazard !== e.haz) begin n_fail++; $display("FAIL byp_after_hazard got %b want %b", rs1_hazard, e.haz); end
  endtask

  task automatic test_flush();
    idle_inputs();
    issue_en = 1'b1; issue_rd = 5'd4; rs1_addr = 5'd4;
    step();
    step();
    issue_en = 1'b0;
    flush = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h77;
    model_wb(wb_addr, wb_data);
    step();
    idle_inputs();
    issue_rd = 5'd4;
    sb_q.push_back('{data: m_regs[4], haz: 1'b0});
    #1;
    e = sb_q.pop_front();
    n_tests++; if (rs1_data !== e.data) begin n_fail++; $display("FAIL flush_data got %h want %h", rs1_data, e.data); end
    n_tests++; if (rs1_hazard !== e.haz) begin n_fail++; $display("FAIL flush_hazard got %b want %b", rs1_hazard, e.haz); end
    n_tests++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL flush_wb_err got %b want 0", wb_err); end
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", issue_ready); end
  endtask

  task automatic test_wb_err();
    idle_inputs();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    model_wb(wb_addr, wb_data);
    #1;
    n_tests++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL err_pre_edge got %b want 0", wb_err); end
    step();
    wb_en = 1'b0; rs2_addr = 5'd3;
    sb_q.push_back('{data: m_regs[3], haz: 1'b0});
    #1;
    e = sb_q.pop_front();
    n_tests++; if (rs2_data !== e.data) begin n_fail++; $display("FAIL err_data got %h want %h", rs2_data, e.data); end
    n_tests++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", wb_err); end
    repeat (3) step();
    n_tests++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", wb_err); end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    issue_en = 1'b1; issue_rd = 5'd6; rs1_addr = 5'd6; rs2_addr = 5'd5;
    step();
    issue_en = 1'b0;
    #1;
    n_tests++; if (rs1_hazard !== 1'b1) begin n_fail++; $display("FAIL arst_pre_hazard got %b want 1", rs1_hazard); end
    n_tests++; if (rs2_data !== m_regs[5]) begin n_fail++; $display("FAIL arst_pre_data got %h want %h", rs2_data, m_regs[5]); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (rs1_hazard !== 1'b0) begin n_fail++; $display("FAIL arst_hazard got %b want 0", rs1_hazard); end
    n_tests++; if (rs2_data !== m_regs[5]) begin n_fail++; $display("FAIL arst_data got %h want %h", rs2_data, m_regs[5]); end
    n_tests++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL arst_wb_err got %b want 0", wb_err); end
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready got %b want 1", issue_ready); end
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_tests++; if (rs1_hazard !== 1'b0) begin n_fail++; $display("FAIL arst_post_hazard got %b want 0", rs1_hazard); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    rs1_addr = '0; rs2_addr = '0;
    test_reset();
    test_write_read();
    test_issue_full();
    test_bypass();
    test_flush();
    test_wb_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
